otter_iobus_responder: RTL

Memory-mapped IOBUS responder on the far end of the OTTER core's IOBUS (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR out of the core, IOBUS_IN back to it). Decodes IO addresses, holds board output registers (LEDs, seven-segment data), synchronizes switch inputs and runs a prescaled 32-bit compare timer with an interrupt output. The core's Memory block registers IOBUS_IN on IO loads, so the read path here is combinational.

---
 rtl/otter_iobus_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/otter_iobus_responder.sv
// OTTER IOBUS responder: address decode, board output registers, switch
// synchronizer and a prescaled 32-bit compare timer with a level interrupt.
module otter_iobus_responder #(
  parameter logic [23:0] BASE_HI = 24'h110000,
  parameter int          SW_W    = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [31:0]     IOBUS_ADDR,
  input  logic [31:0]     IOBUS_OUT,
  input  logic            IOBUS_WR,
  output logic [31:0]     IOBUS_IN,
  input  logic [SW_W-1:0] SWITCHES,
  output logic [SW_W-1:0] LEDS,
  output logic [SW_W-1:0] SSEG_DATA,
  output logic            INTR
);

  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_LED   = 8'h20;
  localparam logic [7:0] OFF_SSEG  = 8'h40;
  localparam logic [7:0] OFF_TCTRL = 8'h60;
  localparam logic [7:0] OFF_TPRE  = 8'h64;
  localparam logic [7:0] OFF_TCMP  = 8'h68;
  localparam logic [7:0] OFF_TCNT  = 8'h6C;
  localparam logic [7:0] OFF_TSTAT = 8'h70;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } tctrl_t;

  logic [SW_W-1:0] sw_meta, sw_sync;
  tctrl_t          ctrl, ctrl_n;
  logic [15:0]     tpre, pcnt, pcnt_n;
  logic [31:0]     tcmp, tcnt, tcnt_n;
  logic            match, match_n;
  logic            hit, wr, tick, match_set;
  logic [7:0]      off;

  assign off = IOBUS_ADDR[7:0];
  assign hit = (IOBUS_ADDR[31:8] == BASE_HI) && (IOBUS_ADDR[1:0] == 2'b00);
  assign wr  = IOBUS_WR && hit;

  // Combinational read mux; the core registers IOBUS_IN on its side.
  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      case (off)
        OFF_SW:    IOBUS_IN = 32'(sw_sync);
        OFF_LED:   IOBUS_IN = 32'(LEDS);
        OFF_SSEG:  IOBUS_IN = 32'(SSEG_DATA);
        OFF_TCTRL: IOBUS_IN = {29'd0, ctrl};
        OFF_TPRE:  IOBUS_IN = {16'd0, tpre};
        OFF_TCMP:  IOBUS_IN = tcmp;
        OFF_TCNT:  IOBUS_IN = tcnt;
        OFF_TSTAT: IOBUS_IN = {31'd0, match};
        default:   IOBUS_IN = '0;
      endcase
    end
  end

  // Timer next state. Compare uses the pre-write TCMP; CPU writes of TCNT
  // override the tick, while a new match overrides a same-edge W1C.
  always_comb begin
    tick      = ctrl.en && (pcnt == tpre);
    match_set = tick && (tcnt == tcmp);
    ctrl_n    = (wr && off == OFF_TCTRL) ? tctrl_t'(IOBUS_OUT[2:0]) : ctrl;

    pcnt_n = pcnt;
    if (wr && off == OFF_TCTRL && !IOBUS_OUT[0]) pcnt_n = '0;
    else if (tick)                                pcnt_n = '0;
    else if (ctrl.en)                             pcnt_n = pcnt + 16'd1;

    tcnt_n = tcnt;
    if (wr && off == OFF_TCNT) tcnt_n = '0;
    else if (match_set)        tcnt_n = ctrl.autoreload ? '0 : tcnt;
    else if (tick)             tcnt_n = tcnt + 32'd1;

    match_n = match;
    if (match_set)                                 match_n = 1'b1;
    else if (wr && off == OFF_TSTAT && IOBUS_OUT[0]) match_n = 1'b0;
  end

  // Register bank, timer state and the flopped interrupt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LEDS      <= '0;
      SSEG_DATA <= '0;
      ctrl      <= '0;
      tpre      <= '0;
      tcmp      <= '0;
      tcnt      <= '0;
      pcnt      <= '0;
      match     <= 1'b0;
      INTR      <= 1'b0;
    end else begin
      if (wr && off == OFF_LED)  LEDS      <= IOBUS_OUT[SW_W-1:0];
      if (wr && off == OFF_SSEG) SSEG_DATA <= IOBUS_OUT[SW_W-1:0];
      if (wr && off == OFF_TPRE) tpre      <= IOBUS_OUT[15:0];
      if (wr && off == OFF_TCMP) tcmp      <= IOBUS_OUT;
      ctrl  <= ctrl_n;
      pcnt  <= pcnt_n;
      tcnt  <= tcnt_n;
      match <= match_n;
      INTR  <= match_n && ctrl_n.irq_en;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
    end
  end

endmodule
